vga_ctrl: RTL and testbench

VGA_CTRL -- requirements
Module: vga_ctrl

---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_delay_line.sv | 25 ++
 rtl/vga_ctrl.sv | 164 ++++++++++++++++
 tb/tb_vga_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: phase enum, default 640x480@60 timing and colour-bar table shared by the VGA controller
package vga_pkg;
  typedef enum logic [1:0] {SYNC, BP, ACT, FP} phase_t;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam logic [23:0] BAR_TABLE = {3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return BAR_TABLE[5'(idx) * 5'd3 +: 3];
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: D-stage W-bit shift register with sync active-low clear; ports clk, clrn, d -> q
module vga_delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s_q [D];
  logic [W-1:0] s_d [D];
  always_comb begin
    s_d[0] = d;
    for (int i = 1; i < D; i++) s_d[i] = s_q[i-1];
  end
  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int i = 0; i < D; i++) s_q[i] <= '0;
    end else begin
      s_q <= s_d;
    end
  end
  assign q = s_q[D-1];
endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing/pixel pipeline; in vga_clk, clrn, pix_r/g/b, tp_en; out row/col_addr, r/g/b, hs, vs, de, line_start, frame_start; option VGA_TEST_PATTERN_EN
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int COLOR_W  = 4,
  parameter int ADDR_W   = 12,
  parameter int PIX_LAT  = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               vga_clk,
  input  logic               clrn,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  input  logic               tp_en,
  output logic [ADDR_W-1:0]  row_addr,
  output logic [ADDR_W-1:0]  col_addr,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic               line_start,
  output logic               frame_start
);
  localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  if (H_ACTIVE > 2**ADDR_W || V_ACTIVE > 2**ADDR_W) begin : g_bad_addr
    $error("vga_ctrl: active area exceeds ADDR_W");
  end
  if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_lat
    $error("vga_ctrl: PIX_LAT out of range 1..4");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_phase
    $error("vga_ctrl: zero-length phase");
  end
  localparam logic [HW-1:0] H_E_SYNC = HW'(H_SYNC - 1);
  localparam logic [HW-1:0] H_E_BP   = HW'(H_SYNC + H_BP - 1);
  localparam logic [HW-1:0] H_E_ACT  = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [HW-1:0] H_E_FP   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_OFF    = HW'(H_SYNC + H_BP);
  localparam logic [VW-1:0] V_E_SYNC = VW'(V_SYNC - 1);
  localparam logic [VW-1:0] V_E_BP   = VW'(V_SYNC + V_BP - 1);
  localparam logic [VW-1:0] V_E_ACT  = VW'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [VW-1:0] V_E_FP   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_OFF    = VW'(V_SYNC + V_BP);
  logic [HW-1:0] h_q, h_d, h_lim;
  logic [VW-1:0] v_q, v_d, v_lim;
  phase_t hph_q, hph_d, vph_q, vph_d;
  logic h_end, v_end, active;
  logic [ADDR_W-1:0] col_d, row_d, col_q, row_q;
  always_comb begin
    h_end = h_q == H_E_FP;
    v_end = v_q == V_E_FP;
    h_d = h_end ? '0 : h_q + 1'b1;
    v_d = h_end ? (v_end ? '0 : v_q + 1'b1) : v_q;
    h_lim = hph_q == SYNC ? H_E_SYNC : hph_q == BP ? H_E_BP : hph_q == ACT ? H_E_ACT : H_E_FP;
    v_lim = vph_q == SYNC ? V_E_SYNC : vph_q == BP ? V_E_BP : vph_q == ACT ? V_E_ACT : V_E_FP;
    hph_d = h_q == h_lim ? phase_t'(hph_q + 2'd1) : hph_q;
    vph_d = h_end && v_q == v_lim ? phase_t'(vph_q + 2'd1) : vph_q;
    active = hph_q == ACT && vph_q == ACT;
    col_d = active ? ADDR_W'(h_q - H_OFF) : '0;
    row_d = active ? ADDR_W'(v_q - V_OFF) : '0;
  end
  always_ff @(posedge vga_clk) begin
    if (!clrn) begin
      h_q   <= '0;
      v_q   <= '0;
      hph_q <= SYNC;
      vph_q <= SYNC;
      col_q <= '0;
      row_q <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      hph_q <= hph_d;
      vph_q <= vph_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end
  assign col_addr = col_q;
  assign row_addr = row_q;
`ifdef VGA_TEST_PATTERN_EN
  localparam int CW = 8;
  localparam int BAR_COLS = H_ACTIVE / 8 > 0 ? H_ACTIVE / 8 : 1;
  logic [ADDR_W-1:0] bar_n;
  logic [2:0] bar, rgb_p;
  always_comb begin
    bar_n = col_d / ADDR_W'(BAR_COLS);
    bar = bar_n > ADDR_W'(7) ? 3'd7 : bar_n[2:0];
  end
  logic [CW-1:0] ctl_d, ctl_p;
  assign ctl_d = {bar, hph_q == SYNC, vph_q == SYNC, active, h_q == '0, h_q == '0 && v_q == '0};
`else
  localparam int CW = 5;
  logic [CW-1:0] ctl_d, ctl_p;
  logic tp_unused;
  assign tp_unused = tp_en;
  assign ctl_d = {hph_q == SYNC, vph_q == SYNC, active, h_q == '0, h_q == '0 && v_q == '0};
`endif
  logic [3*COLOR_W-1:0] pix_s;
  vga_delay_line #(.W(CW), .D(PIX_LAT + 1)) u_ctl (.clk(vga_clk), .clrn(clrn), .d(ctl_d), .q(ctl_p));
  vga_delay_line #(.W(3 * COLOR_W), .D(1)) u_pix (.clk(vga_clk), .clrn(clrn), .d({pix_r, pix_g, pix_b}), .q(pix_s));
  logic [COLOR_W-1:0] sr, sg, sb, r_d, g_d, b_d, r_q, g_q, b_q;
  logic hs_d, vs_d, hs_q, vs_q, de_q, ls_q, fs_q;
  always_comb begin
`ifdef VGA_TEST_PATTERN_EN
    rgb_p = bar_rgb(ctl_p[7:5]);
    sr = tp_en ? {COLOR_W{rgb_p[2]}} : pix_s[3*COLOR_W-1 -: COLOR_W];
    sg = tp_en ? {COLOR_W{rgb_p[1]}} : pix_s[2*COLOR_W-1 -: COLOR_W];
    sb = tp_en ? {COLOR_W{rgb_p[0]}} : pix_s[COLOR_W-1:0];
`else
    sr = pix_s[3*COLOR_W-1 -: COLOR_W];
    sg = pix_s[2*COLOR_W-1 -: COLOR_W];
    sb = pix_s[COLOR_W-1:0];
`endif
    r_d = ctl_p[2] ? sr : '0;
    g_d = ctl_p[2] ? sg : '0;
    b_d = ctl_p[2] ? sb : '0;
    hs_d = ctl_p[4] ? SYNC_POL : ~SYNC_POL;
    vs_d = ctl_p[3] ? SYNC_POL : ~SYNC_POL;
  end
  always_ff @(posedge vga_clk) begin
    if (!clrn) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= ctl_p[2];
      ls_q <= ctl_p[1];
      fs_q <= ctl_p[0];
    end
  end
  assign r = r_q;
  assign g = g_q;
  assign b = b_q;
  assign hs = hs_q;
  assign vs = vs_q;
  assign de = de_q;
  assign line_start = ls_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: scoreboard bench for vga_ctrl across default, latency/polarity, tiny-wrap and test-pattern instances
module tb_vga_ctrl;
  typedef struct packed {
    logic hs, vs, de, ls, fs;
    logic [3:0] r, g, b;
  } exp_t;
  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, lat;
    bit pol;
    bit tp;
  } cfg_t;
  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;
  logic clrn [4];
  logic tp [4];
  logic [3:0] pr [4], pg [4], pb [4], r [4], g [4], b [4];
  logic [11:0] ra [4], ca [4];
  logic hs [4], vs [4], de [4], ls [4], fs [4];
  logic [23:0] dl1, dl2;
  int checks = 0;
  int errors = 0;
  vga_ctrl u0 (.vga_clk(vga_clk), .clrn(clrn[0]), .pix_r(pr[0]), .pix_g(pg[0]), .pix_b(pb[0]), .tp_en(tp[0]),
    .row_addr(ra[0]), .col_addr(ca[0]), .r(r[0]), .g(g[0]), .b(b[0]), .hs(hs[0]), .vs(vs[0]), .de(de[0]),
    .line_start(ls[0]), .frame_start(fs[0]));
  vga_ctrl #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_LAT(3), .SYNC_POL(1'b1)) u1 (.vga_clk(vga_clk), .clrn(clrn[1]), .pix_r(pr[1]), .pix_g(pg[1]),
    .pix_b(pb[1]), .tp_en(tp[1]), .row_addr(ra[1]), .col_addr(ca[1]), .r(r[1]), .g(g[1]), .b(b[1]), .hs(hs[1]),
    .vs(vs[1]), .de(de[1]), .line_start(ls[1]), .frame_start(fs[1]));
  vga_ctrl #(.H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1))
    u2 (.vga_clk(vga_clk), .clrn(clrn[2]), .pix_r(pr[2]), .pix_g(pg[2]), .pix_b(pb[2]), .tp_en(tp[2]),
    .row_addr(ra[2]), .col_addr(ca[2]), .r(r[2]), .g(g[2]), .b(b[2]), .hs(hs[2]), .vs(vs[2]), .de(de[2]),
    .line_start(ls[2]), .frame_start(fs[2]));
  vga_ctrl #(.V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)) u3 (.vga_clk(vga_clk), .clrn(clrn[3]),
    .pix_r(pr[3]), .pix_g(pg[3]), .pix_b(pb[3]), .tp_en(tp[3]), .row_addr(ra[3]), .col_addr(ca[3]),
    .r(r[3]), .g(g[3]), .b(b[3]), .hs(hs[3]), .vs(vs[3]), .de(de[3]), .line_start(ls[3]), .frame_start(fs[3]));
  for (genvar i = 0; i < 4; i++) begin : g_src
    if (i == 1) begin : g_lat3
      assign pr[i] = dl2[3:0];
      assign pg[i] = dl2[15:12];
      assign pb[i] = dl2[7:4];
    end else begin : g_lat1
      assign pr[i] = ca[i][3:0];
      assign pg[i] = ra[i][3:0];
      assign pb[i] = ca[i][7:4];
    end
  end
  always @(posedge vga_clk) begin
    dl1 <= {ra[1], ca[1]};
    dl2 <= dl1;
  end
  function automatic exp_t model(input cfg_t c, input int h, input int v);
    exp_t e;
    int col, row, bar;
    e = '0;
    col = h - c.hs - c.hb;
    row = v - c.vs - c.vb;
    e.hs = h < c.hs ? c.pol : ~c.pol;
    e.vs = v < c.vs ? c.pol : ~c.pol;
    e.de = col >= 0 && col < c.ha && row >= 0 && row < c.va;
    e.ls = h == 0;
    e.fs = h == 0 && v == 0;
    if (e.de) begin
      if (c.tp) begin
        bar = col / (c.ha / 8);
        if (bar > 7) bar = 7;
        e.r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 4'hF : 4'h0;
        e.g = (bar < 4) ? 4'hF : 4'h0;
        e.b = (bar % 2 == 0 && bar < 7) ? 4'hF : 4'h0;
      end else begin
        e.r = 4'(col);
        e.g = 4'(row);
        e.b = 4'(col >> 4);
      end
    end
    return e;
  endfunction
  task automatic run_sb(input int w, input cfg_t c, input int cycles, input int rst_v, input string name);
    exp_t q[$];
    exp_t e, o, rst_e;
    int h, v, since, fs_at, htot, vtot;
    bit fired, in_rst;
    h = 0; v = 0; since = 0; fs_at = -1; fired = 0;
    htot = c.hs + c.hb + c.ha + c.hf;
    vtot = c.vs + c.vb + c.va + c.vf;
    rst_e = '0;
    rst_e.hs = ~c.pol;
    rst_e.vs = ~c.pol;
    tp[w] = c.tp;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      in_rst = cyc < 3 || (rst_v >= 0 && !fired && v == rst_v && h == 1);
      if (in_rst && cyc >= 3) fired = 1;
      if (in_rst) begin
        clrn[w] = 1'b0;
        q.delete();
        repeat (c.lat + 2) q.push_back(rst_e);
        h = 0; v = 0; since = 0;
      end else begin
        clrn[w] = 1'b1;
        q.push_back(model(c, h, v));
        since++;
        if (h == htot - 1) begin
          h = 0;
          v = (v == vtot - 1) ? 0 : v + 1;
        end else h++;
      end
      @(posedge vga_clk);
      #1;
      e = q.pop_front();
      o = {hs[w], vs[w], de[w], ls[w], fs[w], r[w], g[w], b[w]};
      checks++;
      if (o !== e) begin
        errors++;
        if (errors < 20) $display("FAIL %s cyc %0d outputs got %h exp %h", name, cyc, o, e);
      end
      if (in_rst) begin
        checks++;
        if ({ra[w], ca[w]} !== 24'd0) begin
          errors++;
          $display("FAIL %s reset addr got %h exp 0", name, {ra[w], ca[w]});
        end
      end
      if (o.fs === 1'b1 && fs_at < 0) fs_at = since;
    end
    clrn[w] = 1'b0;
    checks++;
    if (fs_at != c.lat + 2) begin
      errors++;
      $display("FAIL %s frame_start latency got %0d exp %0d", name, fs_at, c.lat + 2);
    end
  endtask
  task automatic test_reset_defaults();
    cfg_t c = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0};
    run_sb(0, c, 3 * 800 + 40, -1, "default_timing");
  endtask
  task automatic test_latency_polarity();
    cfg_t c = '{16, 2, 3, 2, 4, 1, 1, 1, 3, 1'b1, 1'b0};
    run_sb(1, c, 3 * 23 * 7 + 20, -1, "lat3_pol1");
  endtask
  task automatic test_wrap_reset();
    cfg_t c = '{2, 1, 1, 1, 2, 1, 1, 1, 1, 1'b0, 1'b0};
    run_sb(2, c, 160, 3, "tiny_wrap_reset");
  endtask
`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    cfg_t c = '{640, 16, 96, 48, 2, 1, 1, 1, 1, 1'b0, 1'b1};
    run_sb(3, c, 5 * 800 + 20, -1, "test_pattern");
  endtask
`endif
  initial begin
    for (int i = 0; i < 4; i++) begin
      clrn[i] = 1'b0;
      tp[i] = 1'b0;
    end
    test_reset_defaults();
    test_latency_polarity();
    test_wrap_reset();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
